// File: rtl/output_fifo.sv
// Output FIFO controller for the convolution accelerator.
// Buffers MAC/output-stage results and presents them on an AXI-Stream-style
// port with show-ahead of the head element. Storage is a dual-port RAM with a
// registered read port and same-address write bypass.

// Simple dual-port RAM: one write port, one registered read port.
// A write to the address being read in the same cycle is forwarded to the
// read register so the new data is visible one cycle later.
module memory_dual_port #(
  parameter int WIDTH = 24,
  parameter int SIZE  = 16,
  localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [SIZE];

  // Array write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read with write-through bypass on address match.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// FIFO control: pointers, occupancy, handshakes and head presentation.
module output_fifo #(
  parameter int  OUTW     = 24,
  parameter int  DEPTH    = 16,
  localparam int LOGDEPTH = $clog2(DEPTH),
  localparam int LOGCAP   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [OUTW-1:0]   IN_AXIS_TDATA,
  input  logic              IN_AXIS_TVALID,
  output logic              IN_AXIS_TREADY,
  output logic [OUTW-1:0]   OUT_AXIS_TDATA,
  output logic              OUT_AXIS_TVALID,
  input  logic              OUT_AXIS_TREADY,
  output logic [LOGCAP-1:0] CAPACITY
);

  localparam logic [LOGDEPTH-1:0] LAST_IDX = LOGDEPTH'(DEPTH - 1);
  localparam logic [LOGCAP-1:0]   FULL_CNT = LOGCAP'(DEPTH);

  logic [LOGDEPTH-1:0] wr_ptr;
  logic [LOGDEPTH-1:0] rd_ptr;
  logic [LOGCAP-1:0]   count;

  logic                push;
  logic                pop;
  logic [LOGDEPTH-1:0] wr_ptr_next;
  logic [LOGDEPTH-1:0] rd_ptr_next;
  logic [LOGDEPTH-1:0] rd_addr;

  // Handshake flags come from the registered count only, so there is no
  // combinational path from TVALID/TREADY inputs to the opposite side.
  always_comb begin
    IN_AXIS_TREADY  = (count != FULL_CNT);
    OUT_AXIS_TVALID = (count != '0);
    CAPACITY        = FULL_CNT - count;
  end

  // Transfer qualification, pointer wrap by explicit compare, read address.
  // Reading next(rd_ptr) on a pop keeps the registered RAM output equal to
  // the new head one cycle later; an idle cycle simply re-reads the head.
  always_comb begin
    push        = IN_AXIS_TVALID & IN_AXIS_TREADY;
    pop         = OUT_AXIS_TVALID & OUT_AXIS_TREADY;
    wr_ptr_next = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + LOGDEPTH'(1);
    rd_ptr_next = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + LOGDEPTH'(1);
    rd_addr     = pop ? rd_ptr_next : rd_ptr;
  end

  // Pointer and occupancy state; reset discards everything queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr_next;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_next;
      end
      case ({push, pop})
        2'b10:   count <= count + LOGCAP'(1);
        2'b01:   count <= count - LOGCAP'(1);
        default: count <= count;
      endcase
    end
  end

  // The bypass covers a push into an empty FIFO (wr_ptr == rd_ptr) and a
  // push to next(rd_ptr) during a pop with one entry left; no other
  // push/read address collision is reachable.
  memory_dual_port #(
    .WIDTH (OUTW),
    .SIZE  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (IN_AXIS_TDATA),
    .rd_addr (rd_addr),
    .rd_data (OUT_AXIS_TDATA)
  );

endmodule

// File: tb/tb_output_fifo.sv
// Self-checking bench for output_fifo: DEPTH=16 and DEPTH=5 instances,
// each compared cycle by cycle against a queue-based reference model.
module tb_output_fifo;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  // Instance A: DEPTH=16
  logic [23:0] a_in_data;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [23:0] a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [4:0]  a_cap;

  // Instance B: DEPTH=5
  logic [23:0] b_in_data;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [23:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [2:0]  b_cap;

  output_fifo #(.OUTW(24), .DEPTH(16)) dut_a (
    .clk             (clk),
    .reset_n         (reset_n),
    .IN_AXIS_TDATA   (a_in_data),
    .IN_AXIS_TVALID  (a_in_valid),
    .IN_AXIS_TREADY  (a_in_ready),
    .OUT_AXIS_TDATA  (a_out_data),
    .OUT_AXIS_TVALID (a_out_valid),
    .OUT_AXIS_TREADY (a_out_ready),
    .CAPACITY        (a_cap)
  );

  output_fifo #(.OUTW(24), .DEPTH(5)) dut_b (
    .clk             (clk),
    .reset_n         (reset_n),
    .IN_AXIS_TDATA   (b_in_data),
    .IN_AXIS_TVALID  (b_in_valid),
    .IN_AXIS_TREADY  (b_in_ready),
    .OUT_AXIS_TDATA  (b_out_data),
    .OUT_AXIS_TVALID (b_out_valid),
    .OUT_AXIS_TREADY (b_out_ready),
    .CAPACITY        (b_cap)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] qa[$];
  logic [23:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive, check at the falling edge,
  // then advance the model across the next rising edge.
  task automatic cycle_a(input logic v, input logic [23:0] d, input logic r);
    bit push, pop;
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = r;
    @(negedge clk);
    chk("a_tready", {31'd0, a_in_ready}, (qa.size() < 16) ? 32'd1 : 32'd0);
    chk("a_tvalid", {31'd0, a_out_valid}, (qa.size() != 0) ? 32'd1 : 32'd0);
    chk("a_capacity", {27'd0, a_cap}, 32'(16 - qa.size()));
    if (qa.size() != 0) chk("a_tdata", {8'd0, a_out_data}, {8'd0, qa[0]});
    push = v && (qa.size() < 16);
    pop  = r && (qa.size() > 0);
    @(posedge clk);
    #1;
    if (pop)  void'(qa.pop_front());
    if (push) qa.push_back(d);
  endtask

  task automatic cycle_b(input logic v, input logic [23:0] d, input logic r);
    bit push, pop;
    b_in_valid  = v;
    b_in_data   = d;
    b_out_ready = r;
    @(negedge clk);
    chk("b_tready", {31'd0, b_in_ready}, (qb.size() < 5) ? 32'd1 : 32'd0);
    chk("b_tvalid", {31'd0, b_out_valid}, (qb.size() != 0) ? 32'd1 : 32'd0);
    chk("b_capacity", {29'd0, b_cap}, 32'(5 - qb.size()));
    if (qb.size() != 0) chk("b_tdata", {8'd0, b_out_data}, {8'd0, qb[0]});
    push = v && (qb.size() < 5);
    pop  = r && (qb.size() > 0);
    @(posedge clk);
    #1;
    if (pop)  void'(qb.pop_front());
    if (push) qb.push_back(d);
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must clear at once.
  task automatic pulse_reset();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_a_tready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_a_tvalid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_a_capacity", {27'd0, a_cap}, 32'd16);
    chk("rst_b_capacity", {29'd0, b_cap}, 32'd5);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    qa.delete();
    qb.delete();
  endtask

  task automatic drain_a();
    for (int i = 0; i < 40 && qa.size() > 0; i++) cycle_a(1'b0, 24'd0, 1'b1);
    cycle_a(1'b0, 24'd0, 1'b0);
  endtask

  initial begin
    int cnt;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset then idle.
    repeat (2) cycle_a(1'b0, 24'd0, 1'b0);

    // Push 5 then 6 with downstream stalled; head must be 5 and stay stable.
    cycle_a(1'b1, 24'd5, 1'b0);
    cycle_a(1'b1, 24'd6, 1'b0);
    repeat (3) cycle_a(1'b0, 24'd0, 1'b0);

    // Mid-cycle asynchronous reset discards both entries.
    pulse_reset();
    cycle_a(1'b0, 24'd0, 1'b0);

    // Fill 1..16, offer 17 while full, then drain in order.
    for (int i = 1; i <= 16; i++) cycle_a(1'b1, 24'(i), 1'b0);
    repeat (2) cycle_a(1'b1, 24'd17, 1'b0);
    drain_a();

    // Pop while full: TREADY only rises the cycle after.
    for (int i = 0; i < 16; i++) cycle_a(1'b1, 24'(32 + i), 1'b0);
    cycle_a(1'b1, 24'd99, 1'b1);
    cycle_a(1'b1, 24'd100, 1'b0);
    drain_a();

    // Fill to 15, then simultaneous push/pop for 40 cycles across wraps.
    cnt = 200;
    for (int i = 0; i < 15; i++) begin cycle_a(1'b1, 24'(cnt), 1'b0); cnt++; end
    for (int i = 0; i < 40; i++) begin cycle_a(1'b1, 24'(cnt), 1'b1); cnt++; end
    drain_a();

    // DEPTH=5: push 0..11 with random downstream ready.
    cnt = 0;
    for (int i = 0; i < 200 && (cnt < 12 || qb.size() > 0); i++) begin
      logic v;
      v = (cnt < 12);
      if (v && qb.size() < 5) begin
        cycle_b(1'b1, 24'(cnt), 1'($urandom_range(0, 1)));
        cnt++;
      end else begin
        cycle_b(v, 24'(cnt), 1'($urandom_range(0, 1)));
      end
    end
    cycle_b(1'b0, 24'd0, 1'b0);

    // Random mixed traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      cycle_a(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 2) != 0 ? 1 : 0));
    end
    for (int i = 0; i < 200; i++) begin
      cycle_b(1'($urandom_range(0, 2) != 0 ? 1 : 0), 24'($urandom), 1'($urandom_range(0, 1)));
    end

    // Push 3, pop 2, reset, push 9: only 9 may come out.
    pulse_reset();
    cycle_a(1'b1, 24'd100, 1'b0);
    cycle_a(1'b1, 24'd101, 1'b0);
    cycle_a(1'b1, 24'd102, 1'b0);
    cycle_a(1'b0, 24'd0, 1'b1);
    cycle_a(1'b0, 24'd0, 1'b1);
    pulse_reset();
    cycle_a(1'b1, 24'd9, 1'b0);
    cycle_a(1'b0, 24'd0, 1'b1);
    repeat (2) cycle_a(1'b0, 24'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
